// File: rtl/scanline_ctrl.sv
// scanline_ctrl: fetches one display line of bytes from VRAM into a 32x8
// scanline buffer (write port A), then hands the bytes to the display one
// per pix_req through the asynchronous read port B.
// Every output is driven from a register that is loaded with its next-cycle value.
module scanline_ctrl #(
  parameter int DEPTH = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_line_start,
  input  logic [15:0] i_line_base,
  output logic        o_vram_req,
  output logic [15:0] o_vram_addr,
  input  logic        i_vram_ack,
  input  logic [7:0]  i_vram_data,
  output logic [4:0]  o_buf_addrA,
  output logic        o_buf_wr_csA,
  output logic [7:0]  o_buf_wr_dataA,
  output logic [4:0]  o_buf_addrB,
  input  logic [7:0]  i_buf_rd_dataB,
  input  logic        i_pix_req,
  output logic [7:0]  o_pix_data,
  output logic        o_pix_valid,
  output logic        o_line_ready,
  output logic        o_busy,
  output logic        o_overrun
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH_REQ = 2'd1,
    S_WRITE     = 2'd2,
    S_DRAIN     = 2'd3
  } state_t;

  // Index of the last byte of a line in both the fill and drain counters.
  localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);

  state_t      r_state;
  state_t      w_next_state;

  logic [15:0] r_base;
  logic [4:0]  r_wr_idx;
  logic [4:0]  r_rd_idx;

  logic        r_vram_req;
  logic [15:0] r_vram_addr;
  logic [4:0]  r_buf_addrA;
  logic        r_buf_wr_csA;
  logic [7:0]  r_buf_wr_dataA;
  logic [7:0]  r_pix_data;
  logic        r_pix_valid;
  logic        r_line_ready;
  logic        r_busy;
  logic        r_overrun;

  logic [15:0] w_base_nx;
  logic [4:0]  w_wr_idx_nx;
  logic [4:0]  w_rd_idx_nx;
  logic        w_vram_req_nx;
  logic [15:0] w_vram_addr_nx;
  logic [4:0]  w_buf_addrA_nx;
  logic        w_buf_wr_csA_nx;
  logic [7:0]  w_buf_wr_dataA_nx;
  logic [7:0]  w_pix_data_nx;
  logic        w_pix_valid_nx;
  logic        w_line_ready_nx;
  logic        w_busy_nx;
  logic        w_overrun_nx;

  // State register: reset drops straight to IDLE without waiting for a clock.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; a line_start in DRAIN wins over a pix_req on the same edge.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_line_start) begin
          w_next_state = S_FETCH_REQ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FETCH_REQ: begin
        if (i_vram_ack) begin
          w_next_state = S_WRITE;
        end else begin
          w_next_state = S_FETCH_REQ;
        end
      end
      S_WRITE: begin
        if (r_wr_idx == LAST_IDX) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_FETCH_REQ;
        end
      end
      S_DRAIN: begin
        if (i_line_start) begin
          w_next_state = S_FETCH_REQ;
        end else if (i_pix_req && (r_rd_idx == LAST_IDX)) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DRAIN;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output/datapath decode: next values for counters, base and every output.
  always_comb begin
    w_base_nx         = r_base;
    w_wr_idx_nx       = r_wr_idx;
    w_rd_idx_nx       = r_rd_idx;
    w_pix_data_nx     = r_pix_data;
    w_pix_valid_nx    = 1'b0;
    w_overrun_nx      = r_overrun;
    w_buf_wr_csA_nx   = 1'b0;
    w_buf_addrA_nx    = 5'd0;
    w_buf_wr_dataA_nx = 8'd0;
    case (r_state)
      S_IDLE: begin
        if (i_line_start) begin
          w_base_nx    = i_line_base;
          w_wr_idx_nx  = 5'd0;
          w_overrun_nx = 1'b0;
        end else begin
          w_base_nx    = r_base;
        end
      end
      S_FETCH_REQ: begin
        if (i_line_start) begin
          w_overrun_nx = 1'b1;
        end else begin
          w_overrun_nx = r_overrun;
        end
        // The write-port registers double as the holding register for the
        // fetched byte, so the WRITE cycle presents it directly.
        if (i_vram_ack) begin
          w_buf_wr_csA_nx   = 1'b1;
          w_buf_addrA_nx    = r_wr_idx;
          w_buf_wr_dataA_nx = i_vram_data;
        end else begin
          w_buf_wr_csA_nx   = 1'b0;
        end
      end
      S_WRITE: begin
        if (i_line_start) begin
          w_overrun_nx = 1'b1;
        end else begin
          w_overrun_nx = r_overrun;
        end
        if (r_wr_idx == LAST_IDX) begin
          w_rd_idx_nx = 5'd0;
        end else begin
          w_wr_idx_nx = r_wr_idx + 5'd1;
        end
      end
      S_DRAIN: begin
        if (i_line_start) begin
          w_overrun_nx = 1'b1;
          w_base_nx    = i_line_base;
          w_wr_idx_nx  = 5'd0;
          w_rd_idx_nx  = 5'd0;
        end else if (i_pix_req) begin
          w_pix_data_nx  = i_buf_rd_dataB;
          w_pix_valid_nx = 1'b1;
          if (r_rd_idx == LAST_IDX) begin
            w_rd_idx_nx = 5'd0;
          end else begin
            w_rd_idx_nx = r_rd_idx + 5'd1;
          end
        end else begin
          w_pix_valid_nx = 1'b0;
        end
      end
      default: begin
        w_pix_valid_nx = 1'b0;
      end
    endcase

    w_vram_req_nx   = (w_next_state == S_FETCH_REQ);
    w_busy_nx       = (w_next_state == S_FETCH_REQ) || (w_next_state == S_WRITE);
    w_line_ready_nx = (w_next_state == S_DRAIN);
    if (w_vram_req_nx) begin
      w_vram_addr_nx = w_base_nx + {11'd0, w_wr_idx_nx};
    end else begin
      w_vram_addr_nx = 16'd0;
    end
  end

  // Datapath and output registers; all cleared asynchronously by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_base         <= 16'd0;
      r_wr_idx       <= 5'd0;
      r_rd_idx       <= 5'd0;
      r_vram_req     <= 1'b0;
      r_vram_addr    <= 16'd0;
      r_buf_addrA    <= 5'd0;
      r_buf_wr_csA   <= 1'b0;
      r_buf_wr_dataA <= 8'd0;
      r_pix_data     <= 8'd0;
      r_pix_valid    <= 1'b0;
      r_line_ready   <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_base         <= w_base_nx;
      r_wr_idx       <= w_wr_idx_nx;
      r_rd_idx       <= w_rd_idx_nx;
      r_vram_req     <= w_vram_req_nx;
      r_vram_addr    <= w_vram_addr_nx;
      r_buf_addrA    <= w_buf_addrA_nx;
      r_buf_wr_csA   <= w_buf_wr_csA_nx;
      r_buf_wr_dataA <= w_buf_wr_dataA_nx;
      r_pix_data     <= w_pix_data_nx;
      r_pix_valid    <= w_pix_valid_nx;
      r_line_ready   <= w_line_ready_nx;
      r_busy         <= w_busy_nx;
      r_overrun      <= w_overrun_nx;
    end
  end

  assign o_vram_req     = r_vram_req;
  assign o_vram_addr    = r_vram_addr;
  assign o_buf_addrA    = r_buf_addrA;
  assign o_buf_wr_csA   = r_buf_wr_csA;
  assign o_buf_wr_dataA = r_buf_wr_dataA;
  assign o_buf_addrB    = r_rd_idx;
  assign o_pix_data     = r_pix_data;
  assign o_pix_valid    = r_pix_valid;
  assign o_line_ready   = r_line_ready;
  assign o_busy         = r_busy;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_scanline_ctrl.sv
// Testbench for scanline_ctrl: VRAM responder and 32x8 buffer model around
// the DUT, with expected addresses, writes and pixels queued at stimulus time.
module tb_scanline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [15:0] line_base;
  logic        vram_req;
  logic [15:0] vram_addr;
  logic        vram_ack;
  logic [7:0]  vram_data;
  logic [4:0]  buf_addrA;
  logic        buf_wr_csA;
  logic [7:0]  buf_wr_dataA;
  logic [4:0]  buf_addrB;
  logic [7:0]  buf_rd_dataB;
  logic        pix_req;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        line_ready;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  int          ack_delay;
  bit          ack_tied;
  int          wait_cnt;
  logic [15:0] tb_base;
  logic [7:0]  tb_off;
  bit          prev_cs;
  bit          prev_pending;
  logic [15:0] prev_addr;
  int          cs_double;
  int          addr_unstable;

  logic [15:0] exp_addr_q[$];
  logic [15:0] obs_addr_q[$];
  logic [12:0] exp_wr_q[$];
  logic [12:0] obs_wr_q[$];
  logic [7:0]  exp_pix_q[$];
  logic [7:0]  obs_pix_q[$];

  logic [7:0]  tb_mem [0:31];

  scanline_ctrl #(.DEPTH(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_line_start(line_start), .i_line_base(line_base),
    .o_vram_req(vram_req), .o_vram_addr(vram_addr), .i_vram_ack(vram_ack), .i_vram_data(vram_data),
    .o_buf_addrA(buf_addrA), .o_buf_wr_csA(buf_wr_csA), .o_buf_wr_dataA(buf_wr_dataA),
    .o_buf_addrB(buf_addrB), .i_buf_rd_dataB(buf_rd_dataB),
    .i_pix_req(pix_req), .o_pix_data(pix_data), .o_pix_valid(pix_valid),
    .o_line_ready(line_ready), .o_busy(busy), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  // Scanline buffer model: synchronous write port A, asynchronous read port B.
  always @(posedge clk) begin
    if (buf_wr_csA) tb_mem[buf_addrA] <= buf_wr_dataA;
  end
  assign buf_rd_dataB = tb_mem[buf_addrB];

  // One cycle: at the falling edge drive the VRAM response and record DUT events.
  task automatic step();
    @(negedge clk);
    if (ack_tied) vram_ack = 1'b1;
    else if (vram_req && wait_cnt == ack_delay) vram_ack = 1'b1;
    else vram_ack = 1'b0;
    vram_data = tb_off + 8'(vram_addr - tb_base);
    if (vram_req && prev_pending && vram_addr !== prev_addr) addr_unstable++;
    prev_pending = vram_req && !vram_ack;
    prev_addr = vram_addr;
    if (vram_req && vram_ack) obs_addr_q.push_back(vram_addr);
    if (!vram_req || vram_ack) wait_cnt = 0; else wait_cnt++;
    if (buf_wr_csA) obs_wr_q.push_back({buf_addrA, buf_wr_dataA});
    if (buf_wr_csA && prev_cs) cs_double++;
    prev_cs = buf_wr_csA;
    if (pix_valid) obs_pix_q.push_back(pix_data);
  endtask

  task automatic clear_queues();
    exp_addr_q.delete(); obs_addr_q.delete(); exp_wr_q.delete();
    obs_wr_q.delete(); exp_pix_q.delete(); obs_pix_q.delete();
    cs_double = 0; addr_unstable = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; line_start = 1'b0; pix_req = 1'b0; line_base = 16'd0;
    step(); step();
    reset = 1'b0;
    wait_cnt = 0; prev_cs = 1'b0; prev_pending = 1'b0;
    step();
    clear_queues();
  endtask

  // Accept a new line and queue the addresses and buffer writes it must produce.
  task automatic start_line(input logic [15:0] base, input logic [7:0] off);
    tb_base = base; tb_off = off;
    for (int i = 0; i < 32; i++) begin
      exp_addr_q.push_back(base + 16'(i));
      exp_wr_q.push_back({5'(i), off + 8'(i)});
    end
    line_base = base; line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  // Cycles from the current point until line_ready is seen; -1 on timeout.
  task automatic wait_ready(input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (line_ready) begin n = k; break; end
    end
  endtask

  task automatic test_reset();
    logic [47:0] outs;
    reset = 1'b1; line_start = 1'b0; pix_req = 1'b0; line_base = 16'd0;
    vram_ack = 1'b0; vram_data = 8'd0;
    #12;
    outs = {vram_req, vram_addr, buf_addrA, buf_wr_csA, buf_wr_dataA, buf_addrB,
            pix_data, pix_valid, line_ready, busy, overrun};
    checks++;
    if (outs !== 48'd0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    do_reset();
    ack_tied = 1'b0; ack_delay = 100;
    start_line(16'h4000, 8'h00);
    step();
    checks++;
    if ({vram_req, busy, vram_addr} !== {2'b11, 16'h4000}) begin
      failures++; $display("FAIL fetch_before_reset: got req=%b busy=%b addr=%h expected 1 1 4000", vram_req, busy, vram_addr);
    end
    #2 reset = 1'b1;
    #1;
    outs = {vram_req, vram_addr, buf_addrA, buf_wr_csA, buf_wr_dataA, buf_addrB,
            pix_data, pix_valid, line_ready, busy, overrun};
    checks++;
    if (outs !== 48'd0) begin failures++; $display("FAIL async_reset_outputs: got %h expected 0", outs); end
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) step();
    outs = {vram_req, vram_addr, buf_addrA, buf_wr_csA, buf_wr_dataA, buf_addrB,
            pix_data, pix_valid, line_ready, busy, overrun};
    checks++;
    if (outs !== 48'd0) begin failures++; $display("FAIL idle_after_reset: got %h expected 0", outs); end
    checks++;
    if (obs_wr_q.size() != 0) begin failures++; $display("FAIL reset_no_write: got %0d writes expected 0", obs_wr_q.size()); end
    clear_queues();
  endtask

  task automatic test_fill();
    int n; logic [15:0] ea, oa; logic [12:0] ew, ow;
    ack_tied = 1'b1;
    start_line(16'h8000, 8'hA0);
    wait_ready(200, n);
    checks++;
    if (n != 64) begin failures++; $display("FAIL fill_latency: got %0d expected 64", n); end
    checks++;
    if ({line_ready, busy} !== 2'b10) begin failures++; $display("FAIL fill_flags: got ready/busy=%b%b expected 10", line_ready, busy); end
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); ew = exp_wr_q.pop_front();
      oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
      ow = (obs_wr_q.size() > 0) ? obs_wr_q.pop_front() : 'x;
      checks += 2;
      if (oa !== ea) begin failures++; $display("FAIL fill_addr: got %h expected %h", oa, ea); end
      if (ow !== ew) begin failures++; $display("FAIL fill_write: got %h expected %h", ow, ew); end
    end
    checks++;
    if (obs_addr_q.size() + obs_wr_q.size() + cs_double != 0) begin
      failures++; $display("FAIL fill_extra: got %0d extra/double events expected 0", obs_addr_q.size() + obs_wr_q.size() + cs_double);
    end
  endtask

  task automatic test_drain();
    logic [7:0] ep, op;
    for (int i = 0; i < 32; i++) exp_pix_q.push_back(8'hA0 + 8'(i));
    pix_req = 1'b1;
    for (int k = 0; k < 40; k++) step();
    pix_req = 1'b0;
    while (exp_pix_q.size() > 0) begin
      ep = exp_pix_q.pop_front();
      op = (obs_pix_q.size() > 0) ? obs_pix_q.pop_front() : 'x;
      checks++;
      if (op !== ep) begin failures++; $display("FAIL drain_pix: got %h expected %h", op, ep); end
    end
    checks++;
    if (obs_pix_q.size() != 0) begin failures++; $display("FAIL drain_extra: got %0d extra pixels expected 0", obs_pix_q.size()); end
    checks++;
    if ({line_ready, busy, pix_valid} !== 3'b000) begin
      failures++; $display("FAIL drain_idle: got ready/busy/valid=%b%b%b expected 000", line_ready, busy, pix_valid);
    end
    clear_queues();
  endtask

  task automatic test_wrap();
    int n; logic [15:0] ea, oa; logic [12:0] ew, ow; logic [7:0] ep, op;
    ack_tied = 1'b0; ack_delay = 0;
    pix_req = 1'b1;
    start_line(16'hFFF0, 8'h11);
    wait_ready(200, n);
    pix_req = 1'b0;
    checks++;
    if (n != 64) begin failures++; $display("FAIL wrap_latency: got %0d expected 64", n); end
    checks++;
    if (obs_pix_q.size() != 0) begin failures++; $display("FAIL pix_ignored: got %0d pixels expected 0", obs_pix_q.size()); end
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); ew = exp_wr_q.pop_front();
      oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
      ow = (obs_wr_q.size() > 0) ? obs_wr_q.pop_front() : 'x;
      checks += 2;
      if (oa !== ea) begin failures++; $display("FAIL wrap_addr: got %h expected %h", oa, ea); end
      if (ow !== ew) begin failures++; $display("FAIL wrap_write: got %h expected %h", ow, ew); end
    end
    for (int i = 0; i < 32; i++) exp_pix_q.push_back(8'h11 + 8'(i));
    pix_req = 1'b1;
    for (int k = 0; k < 34; k++) step();
    pix_req = 1'b0;
    while (exp_pix_q.size() > 0) begin
      ep = exp_pix_q.pop_front();
      op = (obs_pix_q.size() > 0) ? obs_pix_q.pop_front() : 'x;
      checks++;
      if (op !== ep) begin failures++; $display("FAIL wrap_pix: got %h expected %h", op, ep); end
    end
    clear_queues();
  endtask

  task automatic test_wait();
    int n; logic [15:0] ea, oa;
    ack_tied = 1'b0; ack_delay = 3;
    start_line(16'h1234, 8'h40);
    wait_ready(400, n);
    checks++;
    if (n != 160) begin failures++; $display("FAIL wait_latency: got %0d expected 160", n); end
    checks++;
    if (addr_unstable != 0) begin failures++; $display("FAIL wait_addr_stable: got %0d changes expected 0", addr_unstable); end
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
      checks++;
      if (oa !== ea) begin failures++; $display("FAIL wait_addr: got %h expected %h", oa, ea); end
    end
    pix_req = 1'b1;
    for (int k = 0; k < 34; k++) step();
    pix_req = 1'b0;
    clear_queues();
  endtask

  task automatic test_overrun();
    int n; logic [15:0] ea, oa; logic [7:0] ep, op;
    ack_tied = 1'b1;
    start_line(16'h2000, 8'h00);
    for (int k = 0; k < 4; k++) step();
    line_base = 16'h3000; line_start = 1'b1;
    step();
    line_start = 1'b0;
    checks++;
    if ({overrun, busy} !== 2'b11) begin failures++; $display("FAIL overrun_fetch: got ovr/busy=%b%b expected 11", overrun, busy); end
    wait_ready(200, n);
    checks++;
    if (n + 5 != 64) begin failures++; $display("FAIL overrun_latency: got %0d expected 64", n + 5); end
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
      checks++;
      if (oa !== ea) begin failures++; $display("FAIL overrun_addr: got %h expected %h", oa, ea); end
    end
    exp_wr_q.delete(); obs_wr_q.delete();
    for (int i = 0; i < 10; i++) exp_pix_q.push_back(8'(i));
    pix_req = 1'b1;
    for (int k = 0; k < 10; k++) step();
    start_line(16'h3000, 8'h77);
    pix_req = 1'b0;
    checks++;
    if ({pix_valid, line_ready, overrun, busy, vram_req, vram_addr} !== {5'b00111, 16'h3000}) begin
      failures++; $display("FAIL abort_flags: got valid/ready/ovr/busy/req=%b%b%b%b%b addr=%h expected 00111 3000",
                           pix_valid, line_ready, overrun, busy, vram_req, vram_addr);
    end
    while (exp_pix_q.size() > 0) begin
      ep = exp_pix_q.pop_front();
      op = (obs_pix_q.size() > 0) ? obs_pix_q.pop_front() : 'x;
      checks++;
      if (op !== ep) begin failures++; $display("FAIL abort_pix: got %h expected %h", op, ep); end
    end
    checks++;
    if (obs_pix_q.size() != 0) begin failures++; $display("FAIL abort_extra_pix: got %0d expected 0", obs_pix_q.size()); end
    wait_ready(200, n);
    checks++;
    if (n != 64) begin failures++; $display("FAIL refetch_latency: got %0d expected 64", n); end
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
      checks++;
      if (oa !== ea) begin failures++; $display("FAIL refetch_addr: got %h expected %h", oa, ea); end
    end
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    for (int i = 0; i < 32; i++) exp_pix_q.push_back(8'h77 + 8'(i));
    pix_req = 1'b1;
    for (int k = 0; k < 34; k++) step();
    pix_req = 1'b0;
    while (exp_pix_q.size() > 0) begin
      ep = exp_pix_q.pop_front();
      op = (obs_pix_q.size() > 0) ? obs_pix_q.pop_front() : 'x;
      checks++;
      if (op !== ep) begin failures++; $display("FAIL refetch_pix: got %h expected %h", op, ep); end
    end
    start_line(16'h5000, 8'h00);
    checks++;
    if ({overrun, vram_req} !== 2'b01) begin failures++; $display("FAIL overrun_clear: got ovr/req=%b%b expected 01", overrun, vram_req); end
    do_reset();
  endtask

  initial begin
    ack_tied = 1'b0; ack_delay = 0; wait_cnt = 0; tb_base = 16'd0; tb_off = 8'd0;
    prev_cs = 1'b0; prev_pending = 1'b0; prev_addr = 16'd0;
    cs_double = 0; addr_unstable = 0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_wait();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/scanline_ctrl.md
SCANLINE_CTRL -- requirements
Module: scanline_ctrl

Interface
REQ-001 Parameter DEPTH, default 32, SHALL give the number of bytes per line held in the 32x8 scanline buffer.
REQ-002 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 line_start  in  1  SHALL be a one-cycle pulse requesting a fetch of a new line.
REQ-005 line_base  in  16  SHALL be the VRAM base address of the line, sampled when line_start is accepted.
REQ-006 vram_req  out  1  SHALL be the VRAM read request.
REQ-007 vram_addr  out  16  SHALL be the VRAM read address.
REQ-008 vram_ack  in  1  SHALL indicate vram_data is valid this cycle.
REQ-009 vram_data  in  8  SHALL be the VRAM read data.
REQ-010 buf_addrA  out  5  SHALL be the buffer port-A address.
REQ-011 buf_wr_csA  out  1  SHALL be the buffer port-A write enable.
REQ-012 buf_wr_dataA  out  8  SHALL be the buffer port-A write data.
REQ-013 buf_addrB  out  5  SHALL be the buffer port-B address.
REQ-014 buf_rd_dataB  in  8  SHALL be the buffer port-B asynchronous read data.
REQ-015 pix_req  in  1  SHALL be the display request for the next byte.
REQ-016 pix_data  out  8  SHALL be the byte returned to the display.
REQ-017 pix_valid  out  1  SHALL mark pix_data valid for one cycle.
REQ-018 line_ready  out  1  SHALL be high while a complete line is available to drain.
REQ-019 busy  out  1  SHALL be high in FETCH_REQ or WRITE.
REQ-020 overrun  out  1  SHALL be a sticky flag for a line_start that arrived too early.

Function
REQ-021 States SHALL be IDLE, FETCH_REQ, WRITE, DRAIN; 5-bit counters wr_idx and rd_idx; 16-bit base register.
REQ-022 IDLE + line_start: latch line_base, wr_idx=0, clear overrun, go to FETCH_REQ; vram_req is high from the next cycle.
REQ-023 FETCH_REQ: vram_req=1, vram_addr=base+wr_idx (mod 2^16 wrap), held stable until ack; vram_ack is ignored when vram_req=0.
REQ-024 FETCH_REQ + vram_ack: register vram_data and go to WRITE; ack in the first request cycle is legal.
REQ-025 WRITE (one cycle): buf_wr_csA=1, buf_addrA=wr_idx, buf_wr_dataA=registered byte, vram_req=0.
REQ-026 WRITE exit: if wr_idx=DEPTH-1, go to DRAIN with rd_idx=0 and line_ready=1; else increment wr_idx and go to FETCH_REQ.
REQ-027 Fetch throughput SHALL be 2 cycles per byte minimum, so a zero-wait line takes 64 cycles.
REQ-028 DRAIN: buf_addrB=rd_idx continuously; pix_req samples buf_rd_dataB into pix_data, pulses pix_valid the next cycle and increments rd_idx.
REQ-029 DRAIN: the pix_req that consumes byte DEPTH-1 SHALL return to IDLE and drop line_ready on the same edge.
REQ-030 pix_req outside DRAIN SHALL be ignored; pix_valid stays 0.
REQ-031 line_start in FETCH_REQ or WRITE SHALL be ignored and SHALL set overrun.
REQ-032 line_start in DRAIN SHALL abort the drain, set overrun, drop line_ready, latch line_base and enter FETCH_REQ with wr_idx=0; line_start beats a simultaneous pix_req.
REQ-033 Port B SHALL never write; port A SHALL only write in WRITE, so the two ports never collide.

Reset
REQ-034 Reset SHALL force IDLE immediately, regardless of clock.
REQ-035 Reset SHALL zero wr_idx, rd_idx, base, pix_data, and every output (vram_req, vram_addr, buf_*, pix_valid, line_ready, busy, overrun).
REQ-036 Reset mid-fetch SHALL abandon the request with no buf_wr_csA pulse; buffer contents are undefined afterwards.

Verification
REQ-037 Reset asserted in FETCH_REQ with vram_req=1 -> all outputs 0 asynchronously; IDLE after release.
REQ-038 base=0x8000, ack tied high -> 32 requests at 0x8000..0x801F, 32 single-cycle writes to addrA 0..31, line_ready high 64 cycles after the accept edge.
REQ-039 base=0xFFF0 -> addresses 0xFFF0..0xFFFF then 0x0000..0x000F.
REQ-040 ack delayed 3 cycles per byte -> vram_addr stable across the wait; 5 cycles per byte, total 160.
REQ-041 Continuous pix_req after a fill with pattern 8'hA0+i -> 32 pix_valid pulses carrying 0xA0..0xBF in order, then IDLE with line_ready=0.
REQ-042 line_start during fetch -> ignored and overrun=1. line_start after 10 bytes drained -> drain aborted, overrun=1, fetch restarts at the new base, no pix_valid that cycle.
